// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column-strobed 4x4 keypad scanner with frame debounce and key-code FIFO
//
// Ports
//   ACLK          clock
//   ARESET        asynchronous reset, active-high
//   enable        1 = scanning runs, 0 = scan halts after the current column window
//   col_out[3:0]  column drive, active-low, one-cold while a column is strobed
//   row_in[3:0]   raw row inputs, active-low, two-flop synchronised here
//   key_valid     FIFO non-empty, key_code is the oldest queued press
//   key_code[3:0] {col[1:0],row[1:0]} of the oldest press, 0 when empty
//   key_ready     pop strobe, acts when key_valid is high
//   fifo_count    number of queued codes
//   key_pressed   debounced "any key down"
//   overflow      sticky flag: a press was dropped on a full FIFO
//   overflow_clr  clears overflow (a same-cycle drop wins)
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            enable,
    output logic [3:0]                      col_out,
    input  logic [3:0]                      row_in,
    output logic                            key_valid,
    output logic [3:0]                      key_code,
    input  logic                            key_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            key_pressed,
    output logic                            overflow,
    input  logic                            overflow_clr
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE_CNT + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_FRAME} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_div;
    logic [1:0]    r_col;
    logic [3:0]    r_row_s1;
    logic [3:0]    r_row_s2;
    logic [15:0]   r_snap;
    logic [15:0]   r_prev;
    logic [15:0]   r_deb;
    logic [SW-1:0] r_stable;
    logic          r_push;
    logic [3:0]    r_push_code;
    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_kp;

    logic          w_win_end;
    logic          w_same;
    logic          w_accept;
    logic          w_onehot;
    logic          w_event;
    logic [3:0]    w_code;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic          w_drop;

    // last cycle of the current column window
    assign w_win_end = (r_state == S_DRIVE) && (r_div == DW'(SCAN_DIV - 1));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // an enable drop is only honoured at a window end, so a strobed column always completes
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = enable ? S_DRIVE : S_IDLE;
            S_DRIVE: if (w_win_end) w_state_nxt = !enable ? S_IDLE : (r_col == 2'd3 ? S_FRAME : S_DRIVE);
            S_FRAME: w_state_nxt = enable ? S_DRIVE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        col_out = (r_state == S_DRIVE) ? ~(4'b0001 << r_col) : 4'hF;
    end

    // column index and window divider; both park at 0 outside DRIVE
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_div <= '0;
            r_col <= '0;
        end else begin
            r_div <= (r_state != S_DRIVE || w_win_end) ? '0 : r_div + DW'(1);
            r_col <= (r_state != S_DRIVE) ? 2'd0 : (w_win_end ? r_col + 2'd1 : r_col);
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= row_in;
            r_row_s2 <= r_row_s1;
        end
    end

    // snapshot bit col*4+row is 1 for a closed switch; an aborted frame is simply overwritten
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)         r_snap <= '0;
        else if (w_win_end) r_snap[{r_col, 2'b00} +: 4] <= ~r_row_s2;
    end

    assign w_same   = (r_snap == r_prev);
    assign w_accept = (r_state == S_FRAME) && w_same && (r_stable == SW'(DEBOUNCE_CNT - 1));
    assign w_onehot = (r_snap != '0) && ((r_snap & (r_snap - 16'd1)) == '0);
    // only a 0 -> single-key transition is a press; multi-key states lock out further events
    assign w_event  = w_accept && (r_deb == '0) && w_onehot;

    always_comb begin
        w_code = 4'h0;
        for (int i = 0; i < 16; i++) if (r_snap[i]) w_code = 4'(i);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_prev      <= '0;
            r_stable    <= '0;
            r_deb       <= '0;
            r_push      <= 1'b0;
            r_push_code <= 4'h0;
            r_kp        <= 1'b0;
        end else begin
            if (r_state == S_FRAME) begin
                r_prev   <= r_snap;
                r_stable <= !w_same ? '0 : (r_stable != SW'(DEBOUNCE_CNT - 1) ? r_stable + SW'(1) : r_stable);
                if (w_accept) r_deb <= r_snap;
            end
            r_push <= w_event;
            if (w_event) r_push_code <= w_code;
            r_kp <= |r_deb;
        end
    end

    // FWFT FIFO: a full FIFO still accepts a push when the head is popped in the same cycle
    assign w_pop  = key_valid && key_ready;
    assign w_full = (r_cnt == CW'(FIFO_DEPTH));
    assign w_wr   = r_push && (!w_full || w_pop);
    assign w_drop = r_push && w_full && !w_pop;

    always_ff @(posedge ACLK) begin
        if (w_wr) r_mem[r_wr] <= r_push_code;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr)  r_wr <= r_wr + PW'(1);
            if (w_pop) r_rd <= r_rd + PW'(1);
            r_cnt <= r_cnt + CW'(w_wr) - CW'(w_pop);
            r_ovf <= w_drop ? 1'b1 : (overflow_clr ? 1'b0 : r_ovf);
        end
    end

    assign key_valid   = (r_cnt != '0);
    assign key_code    = key_valid ? r_mem[r_rd] : 4'h0;
    assign fifo_count  = r_cnt;
    assign key_pressed = r_kp;
    assign overflow    = r_ovf;
endmodule
